// File: rtl/vram_write_sched.sv
// vram_write_sched
// Owns the single video-memory write port and merges two write sources:
// single-cell CPU writes and hardware block fills (row runs, columns, any
// constant stride). Exactly one write is presented at a time, and it stays
// put until the VGA side grants the port.
//
// Ports:
//   Clock        system clock, rising edge
//   Reset        asynchronous, active-low reset
//   iWrEn        CPU single-write request (one cycle per write)
//   iWrAddr      CPU write address
//   iWrColor     CPU write color
//   iFillStart   fill command pulse (only honoured while idle)
//   iFillFirst   first fill address
//   iFillLast    last fill address, inclusive
//   iFillStride  address step (0 behaves as 1)
//   iFillColor   fill color
//   iVramReady   port grant; a write completes when oVramWe && iVramReady
//   oVramWe      write presented
//   oVramAddr    presented address
//   oVramColor   presented color
//   oBusy        fill in progress
//   oDone        one-cycle pulse when a fill finishes
//   oWrStall     CPU hold register occupied
//   oOverflow    sticky: a CPU write was lost
module vram_write_sched #(
    parameter int ADDR_W  = 10,
    parameter int COLOR_W = 3
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               iWrEn,
    input  logic [ADDR_W-1:0]  iWrAddr,
    input  logic [COLOR_W-1:0] iWrColor,
    input  logic               iFillStart,
    input  logic [ADDR_W-1:0]  iFillFirst,
    input  logic [ADDR_W-1:0]  iFillLast,
    input  logic [ADDR_W-1:0]  iFillStride,
    input  logic [COLOR_W-1:0] iFillColor,
    input  logic               iVramReady,
    output logic               oVramWe,
    output logic [ADDR_W-1:0]  oVramAddr,
    output logic [COLOR_W-1:0] oVramColor,
    output logic               oBusy,
    output logic               oDone,
    output logic               oWrStall,
    output logic               oOverflow
);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t state, state_next;

    logic               hold_valid;
    logic [ADDR_W-1:0]  hold_addr;
    logic [COLOR_W-1:0] hold_color;

    logic [ADDR_W-1:0]  fill_ptr;
    logic [ADDR_W-1:0]  fill_last;
    logic [ADDR_W-1:0]  fill_stride;
    logic [COLOR_W-1:0] fill_color;
    logic               fill_pending;
    logic               slot_fill;

    logic               slot_free;
    logic               start_fill;
    logic [ADDR_W-1:0]  start_stride;
    logic [ADDR_W-1:0]  src_addr;
    logic [ADDR_W-1:0]  src_stride;
    logic [ADDR_W-1:0]  src_last;
    logic [COLOR_W-1:0] src_color;
    logic               fill_valid;
    logic [ADDR_W:0]    fill_sum;
    logic               fill_more;
    logic               take_hold;
    logic               take_cpu;
    logic               take_fill;
    logic               hold_capture;

    assign oWrStall = hold_valid;

    // On the start edge the fill source comes straight from the command
    // inputs, so the first fill write can be presented the very next cycle.
    // The sum is one bit wider than an address so that a wrap past the top
    // of memory shows up as "above last" instead of aliasing low.
    always_comb begin
        slot_free    = !oVramWe || iVramReady;
        start_fill   = (state == IDLE) && iFillStart;
        start_stride = (iFillStride == '0) ? {{(ADDR_W-1){1'b0}}, 1'b1} : iFillStride;
        src_addr     = start_fill ? iFillFirst   : fill_ptr;
        src_stride   = start_fill ? start_stride : fill_stride;
        src_last     = start_fill ? iFillLast    : fill_last;
        src_color    = start_fill ? iFillColor   : fill_color;
        fill_valid   = start_fill ? (iFillFirst <= iFillLast)
                                  : ((state == FILL) && fill_pending);
        fill_sum     = {1'b0, src_addr} + {1'b0, src_stride};
        fill_more    = (fill_sum <= {1'b0, src_last});
        take_hold    = slot_free && hold_valid;
        take_cpu     = slot_free && !hold_valid && iWrEn;
        take_fill    = slot_free && !hold_valid && !iWrEn && fill_valid;
        // A CPU write goes to the hold register either when the slot is busy
        // and the hold is empty, or when the hold is draining into the slot
        // this edge and therefore frees up for the newcomer.
        hold_capture = iWrEn && (slot_free == hold_valid);
    end

    // Output slot and CPU hold register.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            oVramWe    <= 1'b0;
            oVramAddr  <= '0;
            oVramColor <= '0;
            slot_fill  <= 1'b0;
            hold_valid <= 1'b0;
            hold_addr  <= '0;
            hold_color <= '0;
            oOverflow  <= 1'b0;
        end else begin
            if (slot_free) begin
                oVramWe   <= take_hold || take_cpu || take_fill;
                slot_fill <= take_fill;
                if (take_hold) begin
                    oVramAddr  <= hold_addr;
                    oVramColor <= hold_color;
                end else if (take_cpu) begin
                    oVramAddr  <= iWrAddr;
                    oVramColor <= iWrColor;
                end else if (take_fill) begin
                    oVramAddr  <= src_addr;
                    oVramColor <= src_color;
                end else begin
                    oVramAddr  <= '0;
                    oVramColor <= '0;
                end
            end
            if (hold_capture) begin
                hold_valid <= 1'b1;
                hold_addr  <= iWrAddr;
                hold_color <= iWrColor;
            end else if (take_hold) begin
                hold_valid <= 1'b0;
            end
            if (iWrEn && !slot_free && hold_valid) begin
                oOverflow <= 1'b1;
            end
        end
    end

    // Fill command registers and the walking fill pointer. The pointer only
    // moves when a fill write actually enters the slot, so CPU preemption
    // and port stalls never skip or repeat an address.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            fill_ptr     <= '0;
            fill_last    <= '0;
            fill_stride  <= '0;
            fill_color   <= '0;
            fill_pending <= 1'b0;
        end else begin
            if (start_fill) begin
                fill_last   <= iFillLast;
                fill_stride <= start_stride;
                fill_color  <= iFillColor;
            end
            if (take_fill) begin
                fill_ptr     <= fill_sum[ADDR_W-1:0];
                fill_pending <= fill_more;
            end else if (start_fill) begin
                fill_ptr     <= iFillFirst;
                fill_pending <= (iFillFirst <= iFillLast);
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The fill is finished once nothing is left to issue and the slot no
    // longer holds an unaccepted fill write.
    always_comb begin
        state_next = state;
        oBusy      = 1'b0;
        oDone      = 1'b0;
        case (state)
            IDLE: begin
                if (iFillStart) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                oBusy = 1'b1;
                if (!fill_pending && (!slot_fill || iVramReady)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                oDone      = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_vram_write_sched.sv
// Testbench for vram_write_sched: directed fill/CPU scenarios, a queue-based
// reference model compared against the DUT every cycle, and hand-computed
// expectations for write order and fill timing.
module tb_vram_write_sched;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       iWrEn = 1'b0;
    logic [9:0] iWrAddr = '0;
    logic [2:0] iWrColor = '0;
    logic       iFillStart = 1'b0;
    logic [9:0] iFillFirst = '0;
    logic [9:0] iFillLast = '0;
    logic [9:0] iFillStride = '0;
    logic [2:0] iFillColor = '0;
    logic       iVramReady = 1'b1;
    logic       oVramWe;
    logic [9:0] oVramAddr;
    logic [2:0] oVramColor;
    logic       oBusy;
    logic       oDone;
    logic       oWrStall;
    logic       oOverflow;

    int testsRun = 0;
    int testsFailed = 0;

    logic [9:0] accAddr[$];
    logic [2:0] accColor[$];

    vram_write_sched #(.ADDR_W(10), .COLOR_W(3)) dut (
        .Clock(Clock), .Reset(Reset),
        .iWrEn(iWrEn), .iWrAddr(iWrAddr), .iWrColor(iWrColor),
        .iFillStart(iFillStart), .iFillFirst(iFillFirst), .iFillLast(iFillLast),
        .iFillStride(iFillStride), .iFillColor(iFillColor),
        .iVramReady(iVramReady),
        .oVramWe(oVramWe), .oVramAddr(oVramAddr), .oVramColor(oVramColor),
        .oBusy(oBusy), .oDone(oDone), .oWrStall(oWrStall), .oOverflow(oOverflow)
    );

    always #5 Clock = ~Clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] dutPack();
        return {14'd0, oVramWe, oVramAddr, oVramColor, oBusy, oDone, oWrStall, oOverflow};
    endfunction

    // Reference model: a fill is expanded into its full address list up front
    // and consumed from the front whenever the port slot is free and no CPU
    // write claims it.
    logic       mWe, mHoldV, mOvf, mSlotFill;
    logic [9:0] mAddr, mHoldA;
    logic [2:0] mColor, mHoldC, mFillColor;
    int         mPhase;
    logic [9:0] fillQ[$];

    initial begin
        forever begin
            @(posedge Clock or negedge Reset);
            if (!Reset) begin
                mWe = 0; mAddr = 0; mColor = 0; mHoldV = 0; mHoldA = 0; mHoldC = 0;
                mOvf = 0; mSlotFill = 0; mFillColor = 0; mPhase = 0; fillQ.delete();
            end else begin
                int  oldPhase, s;
                logic oldQEmpty, oldSlotFill, starting, free;
                oldPhase    = mPhase;
                oldQEmpty   = (fillQ.size() == 0);
                oldSlotFill = mSlotFill;
                starting    = (mPhase == 0) && iFillStart;
                if (starting) begin
                    fillQ.delete();
                    s = (iFillStride == 0) ? 1 : int'(iFillStride);
                    for (int a = int'(iFillFirst); a <= int'(iFillLast); a += s)
                        fillQ.push_back(10'(a));
                    mFillColor = iFillColor;
                end
                free = !mWe || iVramReady;
                if (free) begin
                    mSlotFill = 0;
                    if (mHoldV) begin
                        mWe = 1; mAddr = mHoldA; mColor = mHoldC;
                        mHoldV = iWrEn;
                        if (iWrEn) begin mHoldA = iWrAddr; mHoldC = iWrColor; end
                    end else if (iWrEn) begin
                        mWe = 1; mAddr = iWrAddr; mColor = iWrColor;
                    end else if ((starting || mPhase == 1) && fillQ.size() > 0) begin
                        mWe = 1; mAddr = fillQ.pop_front(); mColor = mFillColor; mSlotFill = 1;
                    end else begin
                        mWe = 0; mAddr = 0; mColor = 0;
                    end
                end else if (iWrEn) begin
                    if (mHoldV) mOvf = 1;
                    else begin mHoldV = 1; mHoldA = iWrAddr; mHoldC = iWrColor; end
                end
                if (starting) mPhase = 1;
                else if (oldPhase == 1 && oldQEmpty && (!oldSlotFill || iVramReady)) mPhase = 2;
                else if (oldPhase == 2) mPhase = 0;
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    initial begin
        forever begin
            @(negedge Clock);
            #2;
            checkOutput("cycleCompare", dutPack(),
                        {14'd0, mWe, mAddr, mColor, (mPhase == 1), (mPhase == 2), mHoldV, mOvf});
        end
    end

    // Launches one fill and follows it to its done pulse, logging every
    // accepted write. readyMode 1 drives the 1,0,0,1 grant pattern; cpuAt
    // names the cycle (relative to the start edge) in which a CPU write of
    // 0x100/color 5 is requested.
    task automatic applyStimulus(input logic [9:0] first, input logic [9:0] last,
                                 input logic [9:0] stride, input logic [2:0] color,
                                 input int readyMode, input int cpuAt, output int doneCyc);
        int         stableErrs;
        logic       prevHeld;
        logic [13:0] prevSlot;
        stableErrs = 0;
        prevHeld   = 0;
        prevSlot   = '0;
        doneCyc    = -1;
        accAddr.delete();
        accColor.delete();
        @(negedge Clock);
        iFillStart = 1; iFillFirst = first; iFillLast = last;
        iFillStride = stride; iFillColor = color; iVramReady = 1;
        for (int k = 1; k <= 2000 && doneCyc < 0; k++) begin
            @(negedge Clock);
            iFillStart = 0;
            iWrEn      = (k == cpuAt);
            iWrAddr    = 10'h100;
            iWrColor   = 3'd5;
            iVramReady = (readyMode == 1) ? (((k - 1) % 4 == 0) || ((k - 1) % 4 == 3)) : 1'b1;
            #2;
            if (prevHeld && ({oVramWe, oVramAddr, oVramColor} != prevSlot)) stableErrs++;
            if (oVramWe && iVramReady) begin
                accAddr.push_back(oVramAddr);
                accColor.push_back(oVramColor);
            end
            prevHeld = oVramWe && !iVramReady;
            prevSlot = {oVramWe, oVramAddr, oVramColor};
            if (oDone) doneCyc = k;
        end
        iWrEn = 0;
        iVramReady = 1;
        checkOutput("fillTerminated", (doneCyc < 0), 0);
        checkOutput("slotStableWhileNotReady", stableErrs, 0);
    endtask

    initial begin
        int doneCyc, errs, doneSeen;
        logic [9:0] expIl[$];

        // Reset held with random inputs: everything must read zero.
        #1 Reset = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clock);
            iWrEn = 1'($urandom); iWrAddr = 10'($urandom); iWrColor = 3'($urandom);
            iFillStart = 1'($urandom); iFillFirst = 10'($urandom); iFillLast = 10'($urandom);
            iFillStride = 10'($urandom); iFillColor = 3'($urandom); iVramReady = 1'($urandom);
            #2 checkOutput("resetOutputsZero", dutPack(), 0);
        end
        @(negedge Clock);
        iWrEn = 0; iFillStart = 0; iVramReady = 1; Reset = 1;

        // First CPU write after reset appears one cycle later.
        @(negedge Clock);
        iWrEn = 1; iWrAddr = 10'h013; iWrColor = 3'd6;
        @(negedge Clock);
        iWrEn = 0;
        #2 checkOutput("cpuWriteLatency", {oVramWe, oVramAddr, oVramColor}, {1'b1, 10'h013, 3'd6});
        repeat (2) @(negedge Clock);

        // Row fill over the whole memory.
        applyStimulus(10'h000, 10'h3FF, 10'd1, 3'd2, 0, -1, doneCyc);
        checkOutput("rowDoneCycle", doneCyc, 1025);
        checkOutput("rowWriteCount", accAddr.size(), 1024);
        errs = 0;
        foreach (accAddr[i]) if (accAddr[i] != 10'(i) || accColor[i] != 3'd2) errs++;
        checkOutput("rowOrder", errs, 0);

        // Column fill.
        applyStimulus(10'h013, 10'h3FF, 10'h020, 3'd4, 0, -1, doneCyc);
        checkOutput("colWriteCount", accAddr.size(), 32);
        checkOutput("colDoneCycle", doneCyc, 33);
        errs = 0;
        foreach (accAddr[i]) if (accAddr[i] != 10'(19 + 32 * i) || accColor[i] != 3'd4) errs++;
        checkOutput("colOrder", errs, 0);

        // Carry out of the top ends the column after one write.
        applyStimulus(10'h3F0, 10'h3FF, 10'h020, 3'd1, 0, -1, doneCyc);
        checkOutput("carryWriteCount", accAddr.size(), 1);
        if (accAddr.size() > 0) checkOutput("carryAddr", accAddr[0], 10'h3F0);
        checkOutput("carryDoneCycle", doneCyc, 2);

        // Backpressure with the 1,0,0,1 grant pattern; stride 0 acts as 1.
        applyStimulus(10'h040, 10'h047, 10'd0, 3'd3, 1, -1, doneCyc);
        checkOutput("bpWriteCount", accAddr.size(), 8);
        errs = 0;
        foreach (accAddr[i]) if (accAddr[i] != 10'(64 + i)) errs++;
        checkOutput("bpOrder", errs, 0);

        // CPU write dropped into the middle of a fill.
        applyStimulus(10'h200, 10'h20F, 10'd1, 3'd7, 0, 5, doneCyc);
        expIl = '{10'h200, 10'h201, 10'h202, 10'h203, 10'h204, 10'h100, 10'h205, 10'h206, 10'h207,
                  10'h208, 10'h209, 10'h20A, 10'h20B, 10'h20C, 10'h20D, 10'h20E, 10'h20F};
        checkOutput("ilWriteCount", accAddr.size(), 17);
        errs = 0;
        foreach (expIl[i]) if (i >= accAddr.size() || accAddr[i] != expIl[i]) errs++;
        checkOutput("ilOrder", errs, 0);
        if (accColor.size() > 5) checkOutput("ilCpuColor", accColor[5], 3'd5);
        checkOutput("ilDoneCycle", doneCyc, 18);

        // Empty fill.
        applyStimulus(10'd5, 10'd4, 10'd1, 3'd3, 0, -1, doneCyc);
        checkOutput("emptyWriteCount", accAddr.size(), 0);
        checkOutput("emptyDoneCycle", doneCyc, 2);

        // Hold register and overflow with the port withheld.
        accAddr.delete();
        @(negedge Clock);
        iVramReady = 0; iWrEn = 1; iWrAddr = 10'h0AA; iWrColor = 3'd1;
        @(negedge Clock);
        iWrAddr = 10'h0BB; iWrColor = 3'd3;
        @(negedge Clock);
        iWrAddr = 10'h155; iWrColor = 3'd7;
        #2 checkOutput("stallSet", oWrStall, 1);
        @(negedge Clock);
        iWrEn = 0;
        #2 checkOutput("overflowSet", {oOverflow, oWrStall, oVramAddr}, {1'b1, 1'b1, 10'h0AA});
        for (int i = 0; i < 6; i++) begin
            @(negedge Clock);
            iVramReady = 1;
            #2 if (oVramWe && iVramReady) accAddr.push_back(oVramAddr);
        end
        checkOutput("drainCount", accAddr.size(), 2);
        if (accAddr.size() == 2) checkOutput("drainOrder", {accAddr[0], accAddr[1]}, {10'h0AA, 10'h0BB});
        checkOutput("overflowSticky", oOverflow, 1);

        // Fill aborted by reset.
        @(negedge Clock);
        iFillStart = 1; iFillFirst = 10'h000; iFillLast = 10'h3FF; iFillStride = 10'd1; iFillColor = 3'd6;
        @(negedge Clock);
        iFillStart = 0;
        repeat (5) @(negedge Clock);
        Reset = 0;
        #2 checkOutput("abortOutputsZero", dutPack(), 0);
        @(negedge Clock);
        Reset = 1;
        doneSeen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge Clock);
            #2 if (oDone) doneSeen++;
        end
        checkOutput("abortNoDone", doneSeen, 0);

        repeat (2) @(negedge Clock);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/vram_write_sched.md
# vram_write_sched

Write scheduler for the 1024-entry video memory (32×32 cells, 3-bit color). It owns the single VRAM write port and merges two sources: single-cell CPU writes issued by `WVM`, and hardware block fills that replace the software fill loops. The block sits between the CPU execute stage and the video memory. It presents one write at a time, and a write holds stable until the VGA side grants the port.

## Interface
- `ADDR_W`, 10: VRAM address width.
- `COLOR_W`, 3: color width.

- `Clock`  in  1  system clock, rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `iWrEn`  in  1  CPU single-write request, one cycle per write.
- `iWrAddr`  in  ADDR_W  CPU write address.
- `iWrColor`  in  COLOR_W  CPU write color.
- `iFillStart`  in  1  fill command pulse.
- `iFillFirst`  in  ADDR_W  first fill address.
- `iFillLast`  in  ADDR_W  last fill address, inclusive bound.
- `iFillStride`  in  ADDR_W  address step. 1 gives a row run; 32 gives a column.
- `iFillColor`  in  COLOR_W  fill color.
- `iVramReady`  in  1  port grant. A write completes in a cycle where `oVramWe` and `iVramReady` are both 1.
- `oVramWe`  out  1  write presented.
- `oVramAddr`  out  ADDR_W  presented address.
- `oVramColor`  out  COLOR_W  presented color.
- `oBusy`  out  1  fill in progress.
- `oDone`  out  1  one-cycle pulse when a fill finishes.
- `oWrStall`  out  1  CPU hold register occupied.
- `oOverflow`  out  1  sticky flag: a CPU write was lost.

## Operation
- **Reset** (Reset=0, asynchronous): all outputs go to 0; state goes to IDLE; hold register and slot are cleared.
- **Output slot** is the registered `oVramWe`/`oVramAddr`/`oVramColor`. It reloads at a clock edge when the slot is empty (`oVramWe`=0) or is being accepted this cycle. Otherwise all three outputs hold unchanged.
- **Slot source priority:**
  1. Hold register.
  2. `iWrEn`.
  3. Next fill address.

  The slot goes empty if no source is valid.
- **Hold register:**
  - A valid `iWrEn` that cannot load the slot is captured into the hold register, and `oWrStall`=1.
  - `iWrEn` while the hold register is full and not being drained that edge is dropped and sets `oOverflow`, which clears only on reset.
- **State IDLE:**
  - `iFillStart` latches first, last, stride and color, sets the fill pointer to first, and goes to FILL.
  - A stride of 0 is treated as 1.
- **State FILL:**
  - `oBusy`=1.
  - The pointer advances by stride each time a fill write loads the slot.
  - Addition is done at ADDR_W+1 bits. A sum above `iFillLast`, or a carry out, ends the sequence.
  - After the last fill write is accepted, go to DONE.
  - If first > last, no writes are issued; go directly to DONE.
- **State DONE:** `oDone`=1 for one cycle, `oBusy`=0, then return to IDLE.
- `iFillStart` while in FILL or DONE is ignored.
- CPU writes interleave with a fill: each CPU write preempts exactly one fill slot. Fill order is preserved.

## Timing
- **CPU write latency:** `iWrEn` at edge t with slot free → `oVramWe`=1 in cycle t+1.
- **Fill start:** `iFillStart` at edge t → `oBusy`=1 and the first fill write is presented in cycle t+1.
- **Fill throughput:** with `iVramReady` held at 1, N fill writes occupy cycles t+1..t+N and `oDone` pulses in cycle t+N+1. The same cycle, `oBusy` drops to 0.
- **Empty fill** (first > last): `oBusy`=1 in cycle t+1, `oDone` in cycle t+2.
- **Port not granted:** `iVramReady`=0 stalls everything; slot contents and the fill pointer freeze.
- **Reset mid-fill:** the fill is aborted. No `oDone` is issued, and there is no partial-write completion guarantee.
- **Simultaneous events:** `iWrEn` arriving in the same cycle as `iFillStart` loads the slot first. The first fill write then follows one cycle later.

## Test plan
- **Reset:** hold Reset=0 with random inputs → all outputs 0. Release Reset, then `iWrEn` addr=0x013, color=6 → `oVramWe`=1 with addr=0x013, color=6 one cycle later.
- **Row fill:** first=0, last=0x3FF, stride=1, color=2, ready held at 1 → 1024 consecutive writes in address order, `oDone` on cycle 1025, no gaps.
- **Column fill:** first=0x013, last=0x3FF, stride=0x20 → writes to 0x013, 0x033, … 0x3F3 (32 writes), then `oDone`. Also: first=0x3F0, stride=0x20 → exactly one write, because the carry terminates.
- **Backpressure:** during a fill, drive `iVramReady` with a 1,0,0,1 pattern → outputs stable while ready=0, no address skipped or repeated.
- **Interleave:** a CPU write in the middle of a fill (addr 0x100, color 5) → appears between two fill writes. A second `iWrEn` while `oWrStall`=1 with ready=0 → `oOverflow`=1 and that write never appears.
- **Empty fill and abort:** first=5, last=4 → zero writes, `oDone` at t+2. A fill aborted by Reset mid-run → all outputs 0 and no `oDone`.
